// File: rtl/controller_reduce_seq.sv
// Operator-precedence reduction sequencer: drives the shared ALU against the
// operand (dt) and operator (op) stacks on behalf of the calculator controller.
module controller_reduce_seq #(
    parameter int unsigned     DATA_W    = 32,
    parameter int unsigned     OP_W      = 4,
    parameter logic [OP_W-1:0] OP_LPAREN = 4'hF
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              req,
    input  logic [1:0]        req_mode,
    input  logic [OP_W-1:0]   req_op,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code,
    output logic [7:0]        reduce_cnt,
    input  logic [OP_W-1:0]   op_data,
    input  logic              op_empty,
    output logic              op_pop,
    output logic              op_push,
    output logic [OP_W-1:0]   op_push_data,
    input  logic [DATA_W-1:0] dt_data,
    input  logic              dt_empty,
    output logic              dt_pop,
    output logic              dt_push,
    output logic [DATA_W-1:0] dt_push_data,
    output logic [OP_W-1:0]   pr_a,
    output logic [OP_W-1:0]   pr_b,
    input  logic              pr_res,
    output logic              al_start,
    output logic [OP_W-1:0]   al_op,
    output logic [DATA_W-1:0] al_A,
    output logic [DATA_W-1:0] al_B,
    input  logic [DATA_W-1:0] al_C,
    input  logic              al_done,
    input  logic              al_err
);

    typedef enum logic [3:0] {
        S_IDLE, S_CHECK, S_POPOP, S_POPB, S_POPA, S_EXEC,
        S_WAIT, S_PUSHR, S_PUSHOP, S_DONE, S_ERR
    } state_t;

    typedef enum logic [1:0] {
        M_INSERT = 2'b00,
        M_FLUSH  = 2'b01,
        M_PAREN  = 2'b10
    } mode_t;

    state_t            r_state, w_next;
    mode_t             r_mode;
    logic [OP_W-1:0]   r_op, r_cur_op;
    logic [DATA_W-1:0] r_a, r_b, r_c;
    logic              r_err;
    logic [1:0]        r_err_code;
    logic [7:0]        r_cnt;
    logic              w_set_err;
    logic [1:0]        w_err_code;
    logic              w_is_lparen;

    assign w_is_lparen  = (op_data == OP_LPAREN);
    assign busy         = (r_state != S_IDLE);
    assign err          = r_err;
    assign err_code     = r_err_code;
    assign reduce_cnt   = r_cnt;
    assign op_push_data = r_op;
    assign dt_push_data = r_c;
    assign pr_a         = op_data;
    assign pr_b         = r_op;
    assign al_op        = r_cur_op;
    assign al_A         = r_a;
    assign al_B         = r_b;

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            r_state    <= S_IDLE;
            r_mode     <= M_INSERT;
            r_op       <= '0;
            r_cur_op   <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_c        <= '0;
            r_err      <= 1'b0;
            r_err_code <= 2'b00;
            r_cnt      <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: if (req) begin
                    r_op       <= req_op;
                    // reserved mode 11 behaves as flush-all
                    r_mode     <= (req_mode == 2'b00) ? M_INSERT :
                                  (req_mode == 2'b10) ? M_PAREN : M_FLUSH;
                    r_err      <= 1'b0;
                    r_err_code <= 2'b00;
                    r_cnt      <= '0;
                end
                S_POPOP: r_cur_op <= op_data;
                S_POPB:  if (!dt_empty) r_b <= dt_data;
                S_POPA:  if (!dt_empty) r_a <= dt_data;
                S_WAIT:  if (al_done && !al_err) r_c <= al_C;
                S_PUSHR: if (r_cnt != 8'hFF) r_cnt <= r_cnt + 8'd1;
                default: ;
            endcase
            if (w_set_err) begin
                r_err      <= 1'b1;
                r_err_code <= w_err_code;
            end
        end
    end

    always_comb begin
        w_next     = r_state;
        w_set_err  = 1'b0;
        w_err_code = 2'b00;
        op_pop     = 1'b0;
        op_push    = 1'b0;
        dt_pop     = 1'b0;
        dt_push    = 1'b0;
        al_start   = 1'b0;
        done       = 1'b0;
        case (r_state)
            S_IDLE: if (req) w_next = S_CHECK;
            S_CHECK: begin
                case (r_mode)
                    M_INSERT: begin
                        if (op_empty || w_is_lparen || !pr_res) w_next = S_PUSHOP;
                        else                                    w_next = S_POPOP;
                    end
                    M_PAREN: begin
                        if (op_empty) begin
                            w_next     = S_ERR;
                            w_set_err  = 1'b1;
                            w_err_code = 2'b11;
                        end else if (w_is_lparen) begin
                            op_pop = 1'b1;
                            w_next = S_DONE;
                        end else begin
                            w_next = S_POPOP;
                        end
                    end
                    default: begin
                        if (op_empty)         w_next = S_DONE;
                        else if (w_is_lparen) op_pop = 1'b1;
                        else                  w_next = S_POPOP;
                    end
                endcase
            end
            S_POPOP: begin
                op_pop = 1'b1;
                w_next = S_POPB;
            end
            S_POPB, S_POPA: begin
                if (dt_empty) begin
                    w_next     = S_ERR;
                    w_set_err  = 1'b1;
                    w_err_code = 2'b01;
                end else begin
                    dt_pop = 1'b1;
                    w_next = (r_state == S_POPB) ? S_POPA : S_EXEC;
                end
            end
            S_EXEC: begin
                al_start = 1'b1;
                w_next   = S_WAIT;
            end
            S_WAIT: if (al_done) begin
                if (al_err) begin
                    w_next     = S_ERR;
                    w_set_err  = 1'b1;
                    w_err_code = 2'b10;
                end else begin
                    w_next = S_PUSHR;
                end
            end
            S_PUSHR: begin
                dt_push = 1'b1;
                w_next  = S_CHECK;
            end
            S_PUSHOP: begin
                op_push = 1'b1;
                w_next  = S_DONE;
            end
            S_DONE, S_ERR: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_controller_reduce_seq.sv
// Bench for controller_reduce_seq: behavioural stacks/ALU/precedence ROM around
// the DUT, directed vector table, timing/reset sequences and randomized runs.
module tb_controller_reduce_seq;

    localparam logic [3:0] LP = 4'hF;

    logic        Clock = 1'b0;
    logic        Reset = 1'b0;
    logic        req = 1'b0;
    logic [1:0]  req_mode = 2'b00;
    logic [3:0]  req_op = 4'd0;
    logic        busy, done, err;
    logic [1:0]  err_code;
    logic [7:0]  reduce_cnt;
    logic [3:0]  op_data;
    logic        op_empty;
    logic        op_pop, op_push;
    logic [3:0]  op_push_data;
    logic [31:0] dt_data;
    logic        dt_empty;
    logic        dt_pop, dt_push;
    logic [31:0] dt_push_data;
    logic [3:0]  pr_a, pr_b;
    logic        pr_res;
    logic        al_start;
    logic [3:0]  al_op;
    logic [31:0] al_A, al_B;
    logic [31:0] al_C = 32'd0;
    logic        al_done = 1'b0;
    logic        al_err = 1'b0;

    always #5 Clock = ~Clock;

    controller_reduce_seq #(.DATA_W(32), .OP_W(4), .OP_LPAREN(4'hF)) dut (
        .Clock(Clock), .Reset(Reset), .req(req), .req_mode(req_mode), .req_op(req_op),
        .busy(busy), .done(done), .err(err), .err_code(err_code), .reduce_cnt(reduce_cnt),
        .op_data(op_data), .op_empty(op_empty), .op_pop(op_pop), .op_push(op_push),
        .op_push_data(op_push_data), .dt_data(dt_data), .dt_empty(dt_empty),
        .dt_pop(dt_pop), .dt_push(dt_push), .dt_push_data(dt_push_data),
        .pr_a(pr_a), .pr_b(pr_b), .pr_res(pr_res), .al_start(al_start), .al_op(al_op),
        .al_A(al_A), .al_B(al_B), .al_C(al_C), .al_done(al_done), .al_err(al_err)
    );

    // Operators: 1=ADD 2=SUB (prec 1), 3=MUL 4=AND (prec 2).
    function automatic int prec(input logic [3:0] o);
        return (o == 4'd3 || o == 4'd4) ? 2 : 1;
    endfunction

    // {error, result}; SUB errors when it would go negative
    function automatic logic [32:0] alu(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        case (o)
            4'd1:    return {1'b0, a + b};
            4'd2:    return {(a < b), a - b};
            4'd3:    return {1'b0, a * b};
            4'd4:    return {1'b0, a & b};
            default: return {1'b1, 32'd0};
        endcase
    endfunction

    assign pr_res = (prec(pr_a) >= prec(pr_b));

    logic [31:0] dtq[$];
    logic [3:0]  opq[$];
    int unsigned n_dt_pop = 0, n_dt_push = 0, n_op_pop = 0, n_op_push = 0, n_start = 0, n_bad = 0;
    int unsigned alu_cnt = 0, lat_fixed = 0;
    logic [3:0]  p_op;
    logic [31:0] p_a, p_b;

    int unsigned n_chk = 0, n_pass = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h required %0h", name, got, exp);
    endtask

    task automatic refresh();
        dt_empty = (dtq.size() == 0);
        dt_data  = dt_empty ? 32'd0 : dtq[dtq.size()-1];
        op_empty = (opq.size() == 0);
        op_data  = op_empty ? 4'd0 : opq[opq.size()-1];
    endtask

    // Strobes seen mid-cycle take effect just after the following rising edge.
    task automatic env_step();
        logic s_dpop, s_dpush, s_opop, s_opush, s_start;
        logic [31:0] s_dpd, s_a, s_b;
        logic [3:0]  s_opd, s_aop;
        logic [32:0] r;
        @(negedge Clock);
        s_dpop = dt_pop; s_dpush = dt_push; s_dpd = dt_push_data;
        s_opop = op_pop; s_opush = op_push; s_opd = op_push_data;
        s_start = al_start; s_aop = al_op; s_a = al_A; s_b = al_B;
        @(posedge Clock);
        #1;
        if (al_done) begin al_done = 1'b0; al_err = 1'b0; end
        if (s_dpop) begin
            n_dt_pop++;
            if (dtq.size() == 0) n_bad++; else void'(dtq.pop_back());
        end
        if (s_dpush) begin n_dt_push++; dtq.push_back(s_dpd); end
        if (s_opop) begin
            n_op_pop++;
            if (opq.size() == 0) n_bad++; else void'(opq.pop_back());
        end
        if (s_opush) begin n_op_push++; opq.push_back(s_opd); end
        if (s_start) begin
            n_start++;
            p_op = s_aop; p_a = s_a; p_b = s_b;
            alu_cnt = (lat_fixed != 0) ? lat_fixed : $urandom_range(4, 1);
        end
        if (alu_cnt > 0) begin
            alu_cnt--;
            if (alu_cnt == 0) begin
                r = alu(p_op, p_a, p_b);
                al_done = 1'b1; al_err = r[32]; al_C = r[31:0];
            end
        end
        refresh();
    endtask

    // Reference: the precedence-reduction rules applied directly to queues.
    logic [31:0] md[$];
    logic [3:0]  mp[$];
    int unsigned m_cnt, m_nalu, m_dtpop;
    logic        m_err;
    logic [1:0]  m_code;

    task automatic model_run(input logic [1:0] m_in, input logic [3:0] o);
        logic [1:0]  m;
        logic [3:0]  cur;
        logic [31:0] a, b;
        logic [32:0] r;
        bit fin;
        m = (m_in == 2'd3) ? 2'd1 : m_in;
        fin = 0; m_cnt = 0; m_nalu = 0; m_dtpop = 0; m_err = 0; m_code = 0;
        while (!fin) begin
            if (m == 2'd0 && (mp.size() == 0 || mp[mp.size()-1] == LP || prec(mp[mp.size()-1]) < prec(o))) begin
                mp.push_back(o); fin = 1;
            end else if (m != 2'd0 && mp.size() == 0) begin
                if (m == 2'd2) begin m_err = 1; m_code = 2'd3; end
                fin = 1;
            end else if (m != 2'd0 && mp[mp.size()-1] == LP) begin
                void'(mp.pop_back());
                if (m == 2'd2) fin = 1;
            end else begin
                cur = mp.pop_back();
                if (md.size() == 0) begin m_err = 1; m_code = 2'd1; fin = 1; end
                else begin
                    b = md.pop_back(); m_dtpop++;
                    if (md.size() == 0) begin m_err = 1; m_code = 2'd1; fin = 1; end
                    else begin
                        a = md.pop_back(); m_dtpop++; m_nalu++;
                        r = alu(cur, a, b);
                        if (r[32]) begin m_err = 1; m_code = 2'd2; fin = 1; end
                        else begin md.push_back(r[31:0]); if (m_cnt < 255) m_cnt++; end
                    end
                end
            end
        end
    endtask

    task automatic run_req(input logic [1:0] m, input logic [3:0] o, input string tag);
        bit seen;
        seen = 0;
        @(posedge Clock); #2;
        req_mode = m; req_op = o; req = 1'b1;
        @(posedge Clock); #2;
        req = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (done) begin seen = 1; break; end
            @(posedge Clock); #2;
        end
        check({tag, " done seen"}, seen, 1);
        @(posedge Clock); #2;
        check({tag, " idle after done"}, {busy, done}, 2'b00);
    endtask

    typedef struct packed {
        logic [1:0]        mode;
        logic [3:0]        op;
        logic [2:0]        ndt;
        logic [3:0][31:0]  dt;
        logic [2:0]        nop;
        logic [3:0][3:0]   ops;
        logic [2:0]        endt;
        logic [31:0]       etop;
        logic [2:0]        enop;
        logic [3:0]        eotop;
        logic [7:0]        ecnt;
        logic              eerr;
        logic [1:0]        ecode;
        logic [2:0]        edtpop;
        logic [2:0]        enalu;
    } vec_t;

    vec_t vt[$];

    initial begin
        int unsigned b_dpop, b_dpush, b_opush, b_start, got, bad, nd, no;
        refresh();
        fork
            forever env_step();
        join_none

        // Stack contents below are listed bottom-first from the left slot.
        vt.push_back(vec_t'{mode:2'd0, op:4'd1, ndt:3'd0, dt:'0, nop:3'd0, ops:'0,
            endt:3'd0, etop:32'd0, enop:3'd1, eotop:4'd1, ecnt:8'd0, eerr:1'b0, ecode:2'd0, edtpop:3'd0, enalu:3'd0});
        vt.push_back(vec_t'{mode:2'd0, op:4'd1, ndt:3'd2, dt:{32'd2,32'd3,32'd0,32'd0}, nop:3'd1, ops:{4'd3,4'd0,4'd0,4'd0},
            endt:3'd1, etop:32'd6, enop:3'd1, eotop:4'd1, ecnt:8'd1, eerr:1'b0, ecode:2'd0, edtpop:3'd2, enalu:3'd1});
        vt.push_back(vec_t'{mode:2'd1, op:4'd0, ndt:3'd3, dt:{32'd1,32'd2,32'd3,32'd0}, nop:3'd2, ops:{4'd1,4'd3,4'd0,4'd0},
            endt:3'd1, etop:32'd7, enop:3'd0, eotop:4'd0, ecnt:8'd2, eerr:1'b0, ecode:2'd0, edtpop:3'd4, enalu:3'd2});
        vt.push_back(vec_t'{mode:2'd2, op:4'd0, ndt:3'd2, dt:{32'd9,32'd4,32'd0,32'd0}, nop:3'd2, ops:{4'hF,4'd2,4'd0,4'd0},
            endt:3'd1, etop:32'd5, enop:3'd0, eotop:4'd0, ecnt:8'd1, eerr:1'b0, ecode:2'd0, edtpop:3'd2, enalu:3'd1});
        vt.push_back(vec_t'{mode:2'd2, op:4'd0, ndt:3'd0, dt:'0, nop:3'd0, ops:'0,
            endt:3'd0, etop:32'd0, enop:3'd0, eotop:4'd0, ecnt:8'd0, eerr:1'b1, ecode:2'd3, edtpop:3'd0, enalu:3'd0});
        vt.push_back(vec_t'{mode:2'd1, op:4'd0, ndt:3'd1, dt:{32'd5,32'd0,32'd0,32'd0}, nop:3'd1, ops:{4'd1,4'd0,4'd0,4'd0},
            endt:3'd0, etop:32'd0, enop:3'd0, eotop:4'd0, ecnt:8'd0, eerr:1'b1, ecode:2'd1, edtpop:3'd1, enalu:3'd0});
        vt.push_back(vec_t'{mode:2'd1, op:4'd0, ndt:3'd2, dt:{32'd1,32'd4,32'd0,32'd0}, nop:3'd1, ops:{4'd2,4'd0,4'd0,4'd0},
            endt:3'd0, etop:32'd0, enop:3'd0, eotop:4'd0, ecnt:8'd0, eerr:1'b1, ecode:2'd2, edtpop:3'd2, enalu:3'd1});
        vt.push_back(vec_t'{mode:2'd3, op:4'd0, ndt:3'd2, dt:{32'd2,32'd5,32'd0,32'd0}, nop:3'd1, ops:{4'd1,4'd0,4'd0,4'd0},
            endt:3'd1, etop:32'd7, enop:3'd0, eotop:4'd0, ecnt:8'd1, eerr:1'b0, ecode:2'd0, edtpop:3'd2, enalu:3'd1});
        vt.push_back(vec_t'{mode:2'd0, op:4'd3, ndt:3'd2, dt:{32'd2,32'd3,32'd0,32'd0}, nop:3'd1, ops:{4'd1,4'd0,4'd0,4'd0},
            endt:3'd2, etop:32'd3, enop:3'd2, eotop:4'd3, ecnt:8'd0, eerr:1'b0, ecode:2'd0, edtpop:3'd0, enalu:3'd0});
        vt.push_back(vec_t'{mode:2'd0, op:4'd1, ndt:3'd0, dt:'0, nop:3'd1, ops:{4'hF,4'd0,4'd0,4'd0},
            endt:3'd0, etop:32'd0, enop:3'd2, eotop:4'd1, ecnt:8'd0, eerr:1'b0, ecode:2'd0, edtpop:3'd0, enalu:3'd0});
        vt.push_back(vec_t'{mode:2'd1, op:4'd0, ndt:3'd3, dt:{32'd1,32'd2,32'd3,32'd0}, nop:3'd3, ops:{4'd1,4'hF,4'd3,4'd0},
            endt:3'd1, etop:32'd7, enop:3'd0, eotop:4'd0, ecnt:8'd2, eerr:1'b0, ecode:2'd0, edtpop:3'd4, enalu:3'd2});

        Reset = 1'b0;
        repeat (2) @(posedge Clock);
        #2;
        check("reset busy/done", {busy, done}, 2'b00);
        check("reset err/code", {err, err_code}, 3'b000);
        check("reset reduce_cnt", reduce_cnt, 0);
        check("reset strobes", {op_pop, op_push, dt_pop, dt_push, al_start}, 5'b0);
        check("reset latched regs", {op_push_data, al_A, al_B, dt_push_data}, '0);
        Reset = 1'b1;

        // Minimum-latency insert onto an empty op stack
        dtq.delete(); opq.delete(); refresh();
        b_dpop = n_dt_pop; b_dpush = n_dt_push;
        @(posedge Clock); #2;
        req_mode = 2'd0; req_op = 4'd1; req = 1'b1;
        @(posedge Clock); #2;
        req = 1'b0;
        check("lat c1 busy", busy, 1);
        check("lat c1 op_push", op_push, 0);
        @(posedge Clock); #2;
        check("lat c2 op_push", {op_push, op_push_data}, {1'b1, 4'd1});
        check("lat c2 done", done, 0);
        @(posedge Clock); #2;
        check("lat c3 done", done, 1);
        check("lat c3 reduce_cnt", reduce_cnt, 0);
        @(posedge Clock); #2;
        check("lat c4 idle", {busy, done}, 2'b00);
        check("lat dt strobes", (n_dt_pop - b_dpop) + (n_dt_push - b_dpush), 0);

        foreach (vt[k]) begin
            dtq.delete(); opq.delete();
            for (int unsigned i = 0; i < vt[k].ndt; i++) dtq.push_back(vt[k].dt[3-i]);
            for (int unsigned i = 0; i < vt[k].nop; i++) opq.push_back(vt[k].ops[3-i]);
            refresh();
            b_dpop = n_dt_pop; b_dpush = n_dt_push; b_start = n_start;
            run_req(vt[k].mode, vt[k].op, $sformatf("vec%0d", k));
            check($sformatf("vec%0d dt depth", k), dtq.size(), vt[k].endt);
            if (vt[k].endt != 0 && dtq.size() != 0) check($sformatf("vec%0d dt top", k), dtq[dtq.size()-1], vt[k].etop);
            check($sformatf("vec%0d op depth", k), opq.size(), vt[k].enop);
            if (vt[k].enop != 0 && opq.size() != 0) check($sformatf("vec%0d op top", k), opq[opq.size()-1], vt[k].eotop);
            check($sformatf("vec%0d reduce_cnt", k), reduce_cnt, vt[k].ecnt);
            check($sformatf("vec%0d err", k), {err, err_code}, {vt[k].eerr, vt[k].ecode});
            check($sformatf("vec%0d dt_pops", k), n_dt_pop - b_dpop, vt[k].edtpop);
            check($sformatf("vec%0d dt_pushes", k), n_dt_push - b_dpush, vt[k].ecnt);
            check($sformatf("vec%0d al_starts", k), n_start - b_start, vt[k].enalu);
        end

        // Reset while waiting on the ALU: the late al_done must be ignored
        dtq.delete(); opq.delete();
        dtq.push_back(32'd2); dtq.push_back(32'd3); opq.push_back(4'd3);
        refresh();
        lat_fixed = 8;
        b_start = n_start;
        @(posedge Clock); #2;
        req_mode = 2'd1; req_op = 4'd0; req = 1'b1;
        @(posedge Clock); #2;
        req = 1'b0;
        got = 0;
        for (int i = 0; i < 20; i++) begin
            if (n_start != b_start) begin got = 1; break; end
            @(posedge Clock); #2;
        end
        check("rstwait reached WAIT", got, 1);
        @(posedge Clock); #2;
        Reset = 1'b0;
        @(posedge Clock); #2;
        Reset = 1'b1;
        check("rstwait busy after reset", busy, 0);
        check("rstwait outputs cleared", {done, err, err_code, reduce_cnt}, '0);
        b_dpush = n_dt_push;
        repeat (12) @(posedge Clock);
        #2;
        check("rstwait no late dt_push", n_dt_push - b_dpush, 0);
        check("rstwait still idle", {busy, done}, 2'b00);
        lat_fixed = 0;
        dtq.delete(); opq.delete();
        dtq.push_back(32'd4); dtq.push_back(32'd5); opq.push_back(4'd1);
        refresh();
        run_req(2'd1, 4'd0, "post-reset");
        check("post-reset dt", {dtq.size() == 1 ? dtq[0] : 32'hDEAD_BEEF}, 32'd9);
        check("post-reset cnt", reduce_cnt, 1);

        // Randomized requests against the queue model
        for (int unsigned it = 0; it < 150; it++) begin
            logic [1:0] m;
            logic [3:0] o, t;
            dtq.delete(); opq.delete();
            nd = $urandom_range(5, 0);
            no = $urandom_range(4, 0);
            for (int unsigned i = 0; i < nd; i++) dtq.push_back(32'($urandom_range(15, 0)));
            for (int unsigned i = 0; i < no; i++) begin
                t = 4'($urandom_range(5, 1));
                opq.push_back((t == 4'd5) ? LP : t);
            end
            m = 2'($urandom_range(3, 0));
            o = 4'($urandom_range(4, 1));
            md = dtq; mp = opq;
            model_run(m, o);
            refresh();
            b_start = n_start; b_dpop = n_dt_pop; b_opush = n_op_push;
            run_req(m, o, $sformatf("rnd%0d", it));
            check($sformatf("rnd%0d dt depth", it), dtq.size(), md.size());
            bad = 0;
            if (dtq.size() == md.size()) foreach (md[i]) if (dtq[i] !== md[i]) bad++;
            if (opq.size() == mp.size()) foreach (mp[i]) if (opq[i] !== mp[i]) bad++;
            check($sformatf("rnd%0d stack contents", it), bad, 0);
            check($sformatf("rnd%0d op depth", it), opq.size(), mp.size());
            check($sformatf("rnd%0d reduce_cnt", it), reduce_cnt, m_cnt);
            check($sformatf("rnd%0d err", it), {err, err_code}, {m_err, m_code});
            check($sformatf("rnd%0d al_starts", it), n_start - b_start, m_nalu);
            check($sformatf("rnd%0d dt_pops", it), n_dt_pop - b_dpop, m_dtpop);
        end

        check("no pop on empty stack", n_bad, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
